// File: rtl/mem_bus_arbiter_if.sv
// Fetch/data requester ports and external memory bus of mem_bus_arbiter.
// master = arbiter side, slave = requesters plus memory (testbench side).
interface mem_bus_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ready;
  logic        d_req;
  logic        d_write;
  logic [1:0]  d_size;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        bus_err;
  logic [31:0] AD;
  logic        MREQ;
  logic        WRITE;
  logic [1:0]  SIZE;
  logic [31:0] DT_out;
  logic        DT_oe;
  logic [31:0] DT_in;
  logic        ACK_n;

  modport master (
    input  i_req, i_addr, d_req, d_write, d_size, d_addr, d_wdata, DT_in, ACK_n,
    output i_rdata, i_ready, d_rdata, d_ready, bus_err,
           AD, MREQ, WRITE, SIZE, DT_out, DT_oe
  );

  modport slave (
    output i_req, i_addr, d_req, d_write, d_size, d_addr, d_wdata, DT_in, ACK_n,
    input  i_rdata, i_ready, d_rdata, d_ready, bus_err,
           AD, MREQ, WRITE, SIZE, DT_out, DT_oe
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin fetch/data arbiter for one wait-state memory bus; request-to-MREQ 1 cycle,
// ready 1 cycle after ACK_n sampled low; requesters stall until their ready (timeout adds bus_err).
module mem_bus_arbiter #(
  parameter int TIMEOUT = 15,
  parameter int TO_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  mem_bus_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE, I_BUS, D_BUS, DONE} state_t;

  state_t          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            last_grant_q, last_grant_d;  // 1 = data side won last
  logic [31:0]     ad_q, ad_d;
  logic [31:0]     dt_out_q, dt_out_d;
  logic [31:0]     i_rdata_q, i_rdata_d;
  logic [31:0]     d_rdata_q, d_rdata_d;
  logic [1:0]      size_q, size_d;
  logic            mreq_q, mreq_d;
  logic            write_q, write_d;
  logic            dt_oe_q, dt_oe_d;
  logic            i_ready_q, i_ready_d;
  logic            d_ready_q, d_ready_d;
  logic            err_q, err_d;

  logic ack, expired, gnt_data, gnt_fetch;

  assign ack       = ~bus.ACK_n;
  assign expired   = (cnt_q == TO_W'(TIMEOUT - 1));
  assign gnt_data  = bus.d_req && (!bus.i_req || !last_grant_q);
  assign gnt_fetch = bus.i_req && !gnt_data;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    ad_d         = ad_q;
    dt_out_d     = dt_out_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    size_d       = size_q;
    mreq_d       = mreq_q;
    write_d      = write_q;
    dt_oe_d      = dt_oe_q;
    i_ready_d    = 1'b0;
    d_ready_d    = 1'b0;
    err_d        = 1'b0;

    case (state_q)
      IDLE: begin
        if (gnt_data) begin
          state_d      = D_BUS;
          last_grant_d = 1'b1;
          ad_d         = bus.d_addr;
          size_d       = bus.d_size;
          write_d      = bus.d_write;
          dt_oe_d      = bus.d_write;
          dt_out_d     = bus.d_wdata;
          mreq_d       = 1'b1;
        end else if (gnt_fetch) begin
          state_d      = I_BUS;
          last_grant_d = 1'b0;
          ad_d         = bus.i_addr;
          size_d       = 2'b00;
          write_d      = 1'b0;
          dt_oe_d      = 1'b0;
          mreq_d       = 1'b1;
        end
      end

      I_BUS, D_BUS: begin
        cnt_d = cnt_q + 1'b1;
        // ACK wins over timeout when both land in the same cycle
        if (ack || expired) begin
          state_d = DONE;
          mreq_d  = 1'b0;
          write_d = 1'b0;
          dt_oe_d = 1'b0;
          err_d   = ~ack;
          if (state_q == I_BUS) begin
            i_ready_d = 1'b1;
            if (ack) i_rdata_d = bus.DT_in;
          end else begin
            d_ready_d = 1'b1;
            if (ack && !write_q) d_rdata_d = bus.DT_in;
          end
        end
      end

      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b0;
      ad_q         <= '0;
      dt_out_q     <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      size_q       <= '0;
      mreq_q       <= 1'b0;
      write_q      <= 1'b0;
      dt_oe_q      <= 1'b0;
      i_ready_q    <= 1'b0;
      d_ready_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      ad_q         <= ad_d;
      dt_out_q     <= dt_out_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      size_q       <= size_d;
      mreq_q       <= mreq_d;
      write_q      <= write_d;
      dt_oe_q      <= dt_oe_d;
      i_ready_q    <= i_ready_d;
      d_ready_q    <= d_ready_d;
      err_q        <= err_d;
    end
  end

  assign bus.AD      = ad_q;
  assign bus.MREQ    = mreq_q;
  assign bus.WRITE   = write_q;
  assign bus.SIZE    = size_q;
  assign bus.DT_out  = dt_out_q;
  assign bus.DT_oe   = dt_oe_q;
  assign bus.i_rdata = i_rdata_q;
  assign bus.i_ready = i_ready_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.d_ready = d_ready_q;
  assign bus.bus_err = err_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized bench for mem_bus_arbiter: acts as both requesters and the memory,
// predicting grants, bus cycles, readies and read data from a transaction-level model.
module tb_mem_bus_arbiter;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_bus_arbiter_if bif();

  mem_bus_arbiter #(.TIMEOUT(TIMEOUT), .TO_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  int checks = 0;
  int errors = 0;

  // transaction-level reference state
  logic        last_was_d;
  logic        pend_i, pend_d;
  logic [31:0] m_i_addr, m_d_addr, m_d_wdata;
  logic        m_d_write;
  logic [1:0]  m_d_size;
  logic [31:0] m_i_rdata, m_d_rdata;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    last_was_d = 1'b0;
    m_i_rdata  = '0;
    m_d_rdata  = '0;
  endtask

  task automatic post_fetch(input logic [31:0] addr);
    pend_i     = 1'b1;
    m_i_addr   = addr;
    bif.i_req  = 1'b1;
    bif.i_addr = addr;
  endtask

  task automatic post_data(input logic wr, input logic [1:0] sz,
                           input logic [31:0] addr, input logic [31:0] wd);
    pend_d      = 1'b1;
    m_d_write   = wr;
    m_d_size    = sz;
    m_d_addr    = addr;
    m_d_wdata   = wd;
    bif.d_req   = 1'b1;
    bif.d_write = wr;
    bif.d_size  = sz;
    bif.d_addr  = addr;
    bif.d_wdata = wd;
  endtask

  // Called at the falling edge of an IDLE cycle with at least one request pending.
  // k = wait states before ACK (negative: never acknowledge), rd = read data on ACK.
  task automatic service(input int k, input logic [31:0] rd, input bit drop);
    logic        gd, wr;
    logic [31:0] exp_ad;
    int          n;
    gd         = pend_d && (!pend_i || !last_was_d);
    last_was_d = gd;
    wr         = gd && m_d_write;
    exp_ad     = gd ? m_d_addr : m_i_addr;
    n          = 0;

    @(negedge clk);
    check_eq("mreq_rise", 32'(bif.MREQ), 32'd1);
    check_eq("size", 32'(bif.SIZE), 32'(gd ? m_d_size : 2'b00));
    check_eq("write", 32'(bif.WRITE), 32'(wr));
    check_eq("dt_oe", 32'(bif.DT_oe), 32'(wr));
    if (wr) check_eq("dt_out", bif.DT_out, m_d_wdata);
    if (drop) begin
      // the granted requester walks away; its latched request must survive
      if (gd) begin
        bif.d_req   = 1'b0;
        bif.d_addr  = $urandom;
        bif.d_wdata = $urandom;
      end else begin
        bif.i_req  = 1'b0;
        bif.i_addr = $urandom;
      end
    end

    while (bif.MREQ === 1'b1 && n < 40) begin
      n++;
      check_eq("ad", bif.AD, exp_ad);
      check_eq("early_rdy", 32'({bif.i_ready, bif.d_ready, bif.bus_err}), 32'd0);
      if (k >= 0 && n == k + 1) begin
        bif.ACK_n = 1'b0;
        bif.DT_in = rd;
      end else begin
        bif.ACK_n = 1'b1;
        bif.DT_in = $urandom;
      end
      @(negedge clk);
    end

    check_eq("mreq_cycles", n, (k >= 0) ? k + 1 : TIMEOUT);
    check_eq("i_ready", 32'(bif.i_ready), 32'(!gd));
    check_eq("d_ready", 32'(bif.d_ready), 32'(gd));
    check_eq("bus_err", 32'(bif.bus_err), 32'(k < 0));
    if (k >= 0) begin
      if (!gd) m_i_rdata = rd;
      else if (!wr) m_d_rdata = rd;
    end
    check_eq("i_rdata", bif.i_rdata, m_i_rdata);
    check_eq("d_rdata", bif.d_rdata, m_d_rdata);
    if (gd) begin
      bif.d_req = 1'b0;
      pend_d    = 1'b0;
    end else begin
      bif.i_req = 1'b0;
      pend_i    = 1'b0;
    end
    bif.ACK_n = 1'($urandom);
    bif.DT_in = $urandom;

    @(negedge clk);
    check_eq("idle_quiet", 32'({bif.MREQ, bif.i_ready, bif.d_ready, bif.bus_err}), 32'd0);
    bif.ACK_n = 1'($urandom);
    bif.DT_in = $urandom;
  endtask

  initial begin
    rst         = 1'b0;
    bif.i_req   = 1'b0;
    bif.i_addr  = '0;
    bif.d_req   = 1'b0;
    bif.d_write = 1'b0;
    bif.d_size  = '0;
    bif.d_addr  = '0;
    bif.d_wdata = '0;
    bif.DT_in   = '0;
    bif.ACK_n   = 1'b1;
    pend_i      = 1'b0;
    pend_d      = 1'b0;
    m_i_addr    = '0;
    m_d_addr    = '0;
    m_d_wdata   = '0;
    m_d_write   = 1'b0;
    m_d_size    = '0;
    model_reset();

    repeat (2) @(negedge clk);
    check_eq("rst_ctrl", 32'({bif.MREQ, bif.WRITE, bif.DT_oe, bif.i_ready, bif.d_ready, bif.bus_err}), 32'd0);
    check_eq("rst_ad", bif.AD, 32'd0);
    check_eq("rst_size", 32'(bif.SIZE), 32'd0);
    check_eq("rst_dt_out", bif.DT_out, 32'd0);
    check_eq("rst_i_rdata", bif.i_rdata, 32'd0);
    check_eq("rst_d_rdata", bif.d_rdata, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // directed: zero-wait fetch, 3-wait halfword load, store
    post_fetch(32'h0000_0040);
    service(0, 32'h2008_0005, 1'b0);
    post_data(1'b0, 2'b01, 32'h0000_0100, $urandom);
    service(3, 32'hDEAD_BEEF, 1'b0);
    post_data(1'b1, 2'b10, 32'h0000_0200, 32'h1234_5678);
    service(1, $urandom, 1'b0);

    // continuous dual requests alternate
    for (int r = 0; r < 4; r++) begin
      if (!pend_i) post_fetch($urandom);
      if (!pend_d) post_data(1'($urandom), 2'($urandom), $urandom, $urandom);
      service(1, $urandom, 1'b0);
    end

    // timeout abort, then a normal fetch
    post_data(1'b0, 2'b10, 32'h0000_0300, $urandom);
    service(-1, $urandom, 1'b0);
    post_fetch(32'h0000_0044);
    service(2, $urandom, 1'b0);

    // asynchronous reset during the second wait cycle of a fetch
    post_fetch(32'h0000_0080);
    @(negedge clk);
    bif.ACK_n = 1'b1;
    post_data(1'b0, 2'b10, 32'h0000_0400, $urandom);
    @(negedge clk);
    bif.ACK_n = 1'b1;
    #1 rst = 1'b0;
    #1;
    check_eq("arst_quiet", 32'({bif.MREQ, bif.i_ready, bif.d_ready, bif.bus_err}), 32'd0);
    check_eq("arst_ad", bif.AD, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    service(0, $urandom, 1'b0);
    service(1, $urandom, 1'b0);

    // randomized traffic
    for (int t = 0; t < 150; t++) begin
      if (!pend_i && $urandom_range(0, 1) == 1) post_fetch($urandom);
      if (!pend_d && ($urandom_range(0, 1) == 1 || !pend_i))
        post_data(1'($urandom), 2'($urandom), $urandom, $urandom);
      service(($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 3)),
              $urandom, $urandom_range(0, 3) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
